kamus_ctrl: RTL and testbench

Multi-cycle control sequencer for the kamus-v RV32I core. It owns the program counter and steps each instruction through fetch, decode, execute, memory and write-back. It drives the request/grant handshakes to instruction and data memory, gates register-file and instruction-register writes, and raises traps. It consumes the `operation_e` produced by the instruction decoder and the ALU result/branch flag from the datapath.

---
 rtl/kamus_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_kamus_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kamus_ctrl.sv
// kamus_ctrl: multi-cycle FETCH..WB sequencer for kamus-v RV32I (PC, imem/dmem handshakes, traps).
// Latency at zero wait: 4 branch/fence/trap, 5 ALU/jump, 6 store, 7 load; requests held stable until gnt.
// Define KAMUS_MISALIGN_TRAP_EN to trap on misaligned jump/branch targets and data accesses.
package kamus_pkg;

  typedef enum logic [4:0] {
    OP_INVALID = 5'd0,
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU,
    OP_LOAD,
    OP_STORE,
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_FENCE,
    OP_FENCE_I,
    OP_ECALL,
    OP_EBREAK,
    OP_CSR
  } operation_e;

endpackage

module kamus_ctrl
  import kamus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  operation_e  operation_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] alu_res_i,
  input  logic        branch_taken_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  output logic        ir_we_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  output logic        rf_we_o,
  output logic [31:0] pc_o,
  output logic        trap_o,
  output logic [3:0]  mcause_o,
  output logic [31:0] mepc_o,
  output logic        instret_o
);

  localparam logic [3:0] CAUSE_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAK          = 4'd3;
  localparam logic [3:0] CAUSE_LD_MISALIGN    = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN    = 4'd6;
  localparam logic [3:0] CAUSE_ECALL          = 4'd11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_TRAP
  } state_e;

  state_e      r_state, w_state_nxt;
  logic        r_run;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_mepc, w_mepc_nxt;
  logic [3:0]  r_mcause, w_mcause_nxt;
  logic [3:0]  r_cause, w_cause_nxt;

  logic        w_is_branch;
  logic        w_is_fence;
  logic        w_is_jump;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_sys;
  logic [3:0]  w_sys_cause;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_tgt;
  logic        w_tgt_misalign;
  logic        w_mem_misalign;

  assign w_is_branch = operation_i inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  assign w_is_fence  = operation_i inside {OP_FENCE, OP_FENCE_I};
  assign w_is_jump   = operation_i inside {OP_JAL, OP_JALR};
  assign w_is_load   = (operation_i == OP_LOAD);
  assign w_is_store  = (operation_i == OP_STORE);
  assign w_is_sys    = operation_i inside {OP_INVALID, OP_ECALL, OP_EBREAK};

  always_comb begin
    w_sys_cause = CAUSE_ILLEGAL;
    if (operation_i == OP_ECALL) begin
      w_sys_cause = CAUSE_ECALL;
    end else if (operation_i == OP_EBREAK) begin
      w_sys_cause = CAUSE_BREAK;
    end
  end

  assign w_pc_plus4 = r_pc + 32'd4;
  // Branch targets pass through; JALR clears bit0 of the computed target.
  assign w_jump_tgt = (operation_i == OP_JALR) ? {alu_res_i[31:1], 1'b0} : alu_res_i;

`ifdef KAMUS_MISALIGN_TRAP_EN
  assign w_tgt_misalign = (w_jump_tgt[1:0] != 2'b00);
  assign w_mem_misalign = (mem_size_i == 2'b01) ? alu_res_i[0] :
                          (mem_size_i[1]        ? (alu_res_i[1:0] != 2'b00) : 1'b0);
`else
  logic w_unused_size;
  assign w_unused_size  = ^mem_size_i;
  assign w_tgt_misalign = 1'b0;
  assign w_mem_misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_FETCH;
      r_run    <= 1'b0;
      r_pc     <= RESET_PC;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_cause  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= 1'b1;
      r_pc     <= w_pc_nxt;
      r_mepc   <= w_mepc_nxt;
      r_mcause <= w_mcause_nxt;
      r_cause  <= w_cause_nxt;
    end
  end

  // r_run keeps every strobe quiet until the first edge after reset release.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_mepc_nxt   = r_mepc;
    w_mcause_nxt = r_mcause;
    w_cause_nxt  = r_cause;
    imem_req_o   = 1'b0;
    ir_we_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    rf_we_o      = 1'b0;
    trap_o       = 1'b0;
    instret_o    = 1'b0;

    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_gnt_i) begin
            w_state_nxt = S_FETCH_WAIT;
          end
        end

        S_FETCH_WAIT: begin
          if (imem_rvalid_i) begin
            ir_we_o     = 1'b1;
            w_state_nxt = S_DECODE;
          end
        end

        S_DECODE: begin
          if (w_is_sys) begin
            w_cause_nxt = w_sys_cause;
            w_state_nxt = S_TRAP;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end

        S_EXEC: begin
          if (w_is_load || w_is_store) begin
            if (w_mem_misalign) begin
              w_cause_nxt = w_is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
              w_state_nxt = S_TRAP;
            end else begin
              w_state_nxt = S_MEM_REQ;
            end
          end else if (w_is_branch) begin
            if (branch_taken_i && w_tgt_misalign) begin
              w_cause_nxt = CAUSE_IADDR_MISALIGN;
              w_state_nxt = S_TRAP;
            end else begin
              w_pc_nxt    = branch_taken_i ? alu_res_i : w_pc_plus4;
              instret_o   = 1'b1;
              w_state_nxt = S_FETCH;
            end
          end else if (w_is_fence) begin
            w_pc_nxt    = w_pc_plus4;
            instret_o   = 1'b1;
            w_state_nxt = S_FETCH;
          end else if (w_is_jump && w_tgt_misalign) begin
            w_cause_nxt = CAUSE_IADDR_MISALIGN;
            w_state_nxt = S_TRAP;
          end else begin
            w_state_nxt = S_WB;
          end
        end

        S_MEM_REQ: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = w_is_store;
          if (dmem_gnt_i) begin
            w_state_nxt = S_MEM_WAIT;
          end
        end

        S_MEM_WAIT: begin
          if (dmem_rvalid_i) begin
            if (w_is_store) begin
              w_pc_nxt    = w_pc_plus4;
              instret_o   = 1'b1;
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_WB;
            end
          end
        end

        S_WB: begin
          rf_we_o     = 1'b1;
          instret_o   = 1'b1;
          w_pc_nxt    = w_is_jump ? w_jump_tgt : w_pc_plus4;
          w_state_nxt = S_FETCH;
        end

        S_TRAP: begin
          trap_o       = 1'b1;
          w_mepc_nxt   = r_pc;
          w_mcause_nxt = r_cause;
          w_pc_nxt     = TRAP_VEC;
          w_state_nxt  = S_FETCH;
        end

        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign mepc_o      = r_mepc;
  assign mcause_o    = r_mcause;

endmodule

// File: tb/tb_kamus_ctrl.sv
// Bench for kamus_ctrl: a driver plays memory and decoder and pushes predicted per-instruction outcomes;
// a monitor rebuilds each instruction from the DUT outputs and scores it against the queue.
`timescale 1ns/1ps
module tb_kamus_ctrl;
  import kamus_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;
`ifdef KAMUS_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  operation_e  operation_i;
  logic [1:0]  mem_size_i;
  logic [31:0] alu_res_i;
  logic        branch_taken_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic        ir_we_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic        rf_we_o;
  logic [31:0] pc_o;
  logic        trap_o;
  logic [3:0]  mcause_o;
  logic [31:0] mepc_o;
  logic        instret_o;

  always #5 clk_i = ~clk_i;

  kamus_ctrl #(
    .RESET_PC(RST_PC),
    .TRAP_VEC(TVEC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .operation_i(operation_i), .mem_size_i(mem_size_i),
    .alu_res_i(alu_res_i), .branch_taken_i(branch_taken_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .ir_we_o(ir_we_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .rf_we_o(rf_we_o), .pc_o(pc_o), .trap_o(trap_o),
    .mcause_o(mcause_o), .mepc_o(mepc_o), .instret_o(instret_o)
  );

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          rfwe;
    bit          dreq;
    bit          dwe;
    bit          ret;
    bit          trp;
    logic [3:0]  mcause;
    logic [31:0] mepc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          abort  = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_mepc;
  logic [3:0]  m_mcause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    abort = 1'b1;
    $display("FAIL timeout waiting for %s (t=%0t)", what, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Reference model: outcome of one instruction from the architectural rules and latency table.
  task automatic predict(input operation_e op, input logic [31:0] alu, input bit taken,
                         input logic [1:0] size, input int wi, input int wd, output exp_t e);
    logic [31:0] npc;
    logic [31:0] tgt;
    logic [3:0]  cause;
    bit          trap;
    bit          misal;
    e = '{pc: m_pc, lat: 0, rfwe: 0, dreq: 1'b0, dwe: 1'b0, ret: 1'b0, trp: 1'b0,
          mcause: m_mcause, mepc: m_mepc};
    npc   = m_pc + 32'd4;
    trap  = 1'b0;
    cause = 4'd0;
    case (op)
      OP_INVALID: begin trap = 1'b1; cause = 4'd2;  e.lat = 4; end
      OP_ECALL:   begin trap = 1'b1; cause = 4'd11; e.lat = 4; end
      OP_EBREAK:  begin trap = 1'b1; cause = 4'd3;  e.lat = 4; end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        if (taken) npc = alu;
        if (taken && MIS_EN && (alu % 4 != 0)) begin
          trap = 1'b1; e.lat = 5;
        end else begin
          e.lat = 4; e.ret = 1'b1;
        end
      end
      OP_FENCE, OP_FENCE_I: begin e.lat = 4; e.ret = 1'b1; end
      OP_JAL, OP_JALR: begin
        tgt = (op == OP_JALR) ? (alu & 32'hFFFF_FFFE) : alu;
        if (MIS_EN && (tgt % 4 != 0)) begin
          trap = 1'b1; e.lat = 5;
        end else begin
          npc = tgt; e.lat = 5; e.rfwe = 1; e.ret = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: begin
        misal = (size == 2'b01) ? (alu % 2 != 0) : (size == 2'b10) ? (alu % 4 != 0) : 1'b0;
        if (MIS_EN && misal) begin
          trap = 1'b1; cause = (op == OP_LOAD) ? 4'd4 : 4'd6; e.lat = 5;
        end else begin
          e.dreq = 1'b1;
          e.dwe  = (op == OP_STORE);
          e.lat  = ((op == OP_STORE) ? 6 : 7) + wd;
          e.rfwe = (op == OP_LOAD) ? 1 : 0;
          e.ret  = 1'b1;
        end
      end
      default: begin e.lat = 5; e.rfwe = 1; e.ret = 1'b1; end
    endcase
    e.lat = e.lat + wi;
    if (trap) begin
      e.trp    = 1'b1;
      npc      = TVEC;
      m_mepc   = m_pc;
      m_mcause = cause;
      e.mcause = cause;
      e.mepc   = m_pc;
    end
    m_pc = npc;
  endtask

  task automatic issue(input operation_e op, input logic [31:0] alu, input bit taken,
                       input logic [1:0] size, input int gw, input int rw, input int dgw, input int drw);
    exp_t e;
    int   t;
    if (abort) return;
    t = 0;
    while (!imem_req_o) begin
      step();
      t++;
      if (t > 64) begin timeout("imem_req_o"); return; end
    end
    predict(op, alu, taken, size, gw + rw, dgw + drw, e);
    exp_q.push_back(e);
    operation_i    = op;
    alu_res_i      = alu;
    branch_taken_i = taken;
    mem_size_i     = size;
    repeat (gw) begin imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; step(); end
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b1; step();
    imem_gnt_i    = 1'b0;
    repeat (rw) step();
    imem_rvalid_i = 1'b1; step();
    imem_rvalid_i = 1'b0;
    if (e.dreq) begin
      t = 0;
      while (!dmem_req_o) begin
        step();
        t++;
        if (t > 16) begin timeout("dmem_req_o"); return; end
      end
      repeat (dgw) step();
      dmem_gnt_i = 1'b1; step();
      dmem_gnt_i = 1'b0;
      repeat (drw) step();
      dmem_rvalid_i = 1'b1; step();
      dmem_rvalid_i = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc_o, RST_PC);
    chk({tag, "_mepc"}, mepc_o, 32'h0);
    chk({tag, "_mcause"}, 32'(mcause_o), 32'h0);
    chk({tag, "_strobes"}, 32'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, trap_o, instret_o}), 32'h0);
  endtask

  task automatic reset_mid_store();
    int t;
    if (abort) return;
    t = 0;
    while (!imem_req_o) begin
      step();
      t++;
      if (t > 64) begin timeout("imem_req_o"); return; end
    end
    operation_i = OP_STORE; alu_res_i = 32'h300; mem_size_i = 2'b10; branch_taken_i = 1'b0;
    imem_gnt_i = 1'b1; step(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; step(); imem_rvalid_i = 1'b0;
    t = 0;
    while (!dmem_req_o) begin
      step();
      t++;
      if (t > 16) begin timeout("dmem_req_o"); return; end
    end
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    step();
    #2 rst_ni = 1'b0;
    #1;
    check_reset_state("midrst");
    dmem_rvalid_i = 1'b1;
    imem_rvalid_i = 1'b1;
    step();
    step();
    rst_ni = 1'b1;
    step();
    chk("midrst_first_req", 32'(imem_req_o), 32'h1);
    chk("midrst_first_addr", imem_addr_o, RST_PC);
    dmem_rvalid_i = 1'b0;
    m_pc = RST_PC; m_mepc = 32'h0; m_mcause = 4'd0;
    issue(OP_ADD, 32'h1234, 1'b0, 2'b10, 2, 0, 0, 0);
  endtask

  // Monitor: an instruction spans from one rising imem_req_o to the next.
  bit          open_rec;
  bit          prev_req;
  logic [31:0] o_pc;
  int          o_cyc, o_lat, o_rfwe, o_dreq, o_ret, o_trp, o_irwe;
  bit          o_dwe, bad_stable, bad_excl, bad_addr;

  task automatic close_rec();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected instruction at pc %h: no prediction pending", o_pc);
      return;
    end
    e = exp_q.pop_front();
    chk("fetch_pc", o_pc, e.pc);
    chk("latency", 32'(o_lat), 32'(e.lat));
    chk("rf_we_count", 32'(o_rfwe), 32'(e.rfwe));
    chk("dmem_req_seen", 32'(o_dreq > 0), 32'(e.dreq));
    chk("dmem_we", 32'(o_dwe), 32'(e.dwe));
    chk("instret_count", 32'(o_ret), 32'(e.ret));
    chk("trap_count", 32'(o_trp), 32'(e.trp));
    chk("ir_we_count", 32'(o_irwe), 32'h1);
    chk("mcause", 32'(mcause_o), 32'(e.mcause));
    chk("mepc", mepc_o, e.mepc);
    chk("req_stable", 32'(bad_stable), 32'h0);
    chk("strobe_exclusive", 32'(bad_excl), 32'h0);
    chk("imem_addr_eq_pc", 32'(bad_addr), 32'h0);
  endtask

  initial begin : monitor
    open_rec = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        open_rec = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (imem_req_o && !prev_req) begin
          if (open_rec) close_rec();
          open_rec = 1'b1;
          o_pc = imem_addr_o;
          o_cyc = 0; o_lat = 0; o_rfwe = 0; o_dreq = 0; o_ret = 0; o_trp = 0; o_irwe = 0;
          o_dwe = 1'b0; bad_stable = 1'b0; bad_excl = 1'b0; bad_addr = 1'b0;
        end
        if (open_rec) begin
          o_cyc++;
          if (imem_req_o && imem_addr_o !== o_pc) bad_stable = 1'b1;
          if (imem_addr_o !== pc_o) bad_addr = 1'b1;
          if ((int'(imem_req_o) + int'(dmem_req_o) + int'(rf_we_o)) > 1) bad_excl = 1'b1;
          if (dmem_req_o) begin
            if (o_dreq == 0) o_dwe = dmem_we_o;
            else if (dmem_we_o !== o_dwe) bad_stable = 1'b1;
            o_dreq++;
          end
          if (rf_we_o) o_rfwe++;
          if (ir_we_o) o_irwe++;
          if (instret_o) begin o_ret++; o_lat = o_cyc; end
          if (trap_o) begin o_trp++; o_lat = o_cyc; end
        end
        prev_req = imem_req_o;
      end
    end
  end

  initial begin : stimulus
    int t;
    rst_ni = 1'b0;
    operation_i = OP_ADD; mem_size_i = 2'b10; alu_res_i = '0; branch_taken_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    m_pc = RST_PC; m_mepc = 32'h0; m_mcause = 4'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_state("reset");
    rst_ni = 1'b1;
    step();
    chk("first_req", 32'(imem_req_o), 32'h1);
    chk("first_addr", imem_addr_o, RST_PC);

    repeat (3) issue(OP_ADD, $urandom, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_LOAD, 32'h0000_0200, 1'b0, 2'b10, 2, 0, 0, 3);
    issue(OP_BEQ, 32'h0000_0040, 1'b1, 2'b10, 0, 0, 0, 0);
    issue(OP_BEQ, 32'h0000_0800, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_JAL, 32'h0000_0020, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_INVALID, 32'h0, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_ECALL, 32'h0, 1'b0, 2'b10, 0, 1, 0, 0);
    issue(OP_EBREAK, 32'h0, 1'b0, 2'b10, 1, 0, 0, 0);
    issue(OP_LOAD, 32'h0000_0102, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_STORE, 32'h0000_0102, 1'b0, 2'b01, 0, 0, 1, 1);
    issue(OP_FENCE, 32'h0, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_JALR, 32'hFFFF_FFFD, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_ADD, 32'h0, 1'b0, 2'b10, 0, 0, 0, 0);
    issue(OP_STORE, 32'h0000_0400, 1'b0, 2'b10, 1, 1, 2, 2);
    reset_mid_store();

    for (int i = 0; i < 200; i++) begin
      operation_e  op;
      logic [31:0] a;
      op = operation_e'(5'($urandom_range(0, 27)));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      issue(op, a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            rnd_wait(), rnd_wait(), rnd_wait(), rnd_wait());
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
